// File: rtl/fsm1_driver_if.sv
// Command/response bundle between the run harness and fsm1_driver.
// The harness drives through master; the driver sits on slave.
interface fsm1_driver_if;
  logic       cmd_valid;
  logic [1:0] cmd_target;
  logic       cmd_ready;
  logic       rsp_valid;
  logic       rsp_error;
  logic [1:0] rsp_steps;
  logic       busy;

  modport master (
    output cmd_valid,
    output cmd_target,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_error,
    input  rsp_steps,
    input  busy
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    output cmd_ready,
    output rsp_valid,
    output rsp_error,
    output rsp_steps,
    output busy
  );
endinterface

// File: rtl/fsm1_driver.sv
// Steers the three-state A/B/C FSM into a requested state by
// issuing one-cycle input pulses and watching its state feedback.
module fsm1_driver #(
  parameter int TIMEOUT = 8,
  parameter int TW      = 4
) (
  input  logic         clk,
  input  logic         reset,
  fsm1_driver_if.slave bus,
  input  logic         state_obs1,
  input  logic         state_obs0,
  output logic         input1,
  output logic         input2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAN,
    S_DRIVE,
    S_WAIT,
    S_RESP
  } st_t;

  st_t           state_q, state_d;
  logic [1:0]    tgt_q, tgt_d;
  logic [1:0]    exp_q, exp_d;
  logic [1:0]    prev_q, prev_d;
  logic [1:0]    steps_q, steps_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic [1:0]    drv_q, drv_d;
  logic [1:0]    obs;
  logic [1:0]    plan_pair;
  logic [1:0]    plan_exp;

  assign obs = {state_obs1, state_obs0};

  // One hop toward the target; B and C only have one exit each.
  always_comb begin
    plan_pair = 2'b10;
    plan_exp  = 2'b01;
    unique case (obs)
      2'b00: begin
        plan_pair = tgt_q;
        plan_exp  = tgt_q;
      end
      2'b01: begin
        plan_pair = 2'b11;
        plan_exp  = 2'b00;
      end
      default: begin
        plan_pair = 2'b10;
        plan_exp  = 2'b01;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    exp_d   = exp_q;
    prev_d  = prev_q;
    steps_d = steps_q;
    timer_d = timer_q;
    err_d   = err_q;
    drv_d   = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          tgt_d   = bus.cmd_target;
          steps_d = 2'd0;
          err_d   = 1'b0;
          state_d = S_PLAN;
        end
      end
      S_PLAN: begin
        if (tgt_q == 2'b11 || obs == 2'b11) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (obs == tgt_q) begin
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          drv_d   = plan_pair;
          exp_d   = plan_exp;
          prev_d  = obs;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        steps_d = steps_q + 2'd1;
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (obs == exp_q && exp_q == tgt_q) begin
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (obs == exp_q) begin
          state_d = S_PLAN;
        end else if (obs != prev_q) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tgt_q   <= 2'b00;
      exp_q   <= 2'b00;
      prev_q  <= 2'b00;
      steps_q <= 2'd0;
      timer_q <= '0;
      err_q   <= 1'b0;
      drv_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      exp_q   <= exp_d;
      prev_q  <= prev_d;
      steps_q <= steps_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      drv_q   <= drv_d;
    end
  end

  assign input1        = drv_q[1];
  assign input2        = drv_q[0];
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.cmd_ready = (state_q == S_IDLE) && !reset;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_error = bus.rsp_valid & err_q;
  assign bus.rsp_steps = bus.rsp_valid ? steps_q : 2'd0;

endmodule

// File: tb/tb_fsm1_driver.sv
// Drives fsm1_driver against a small A/B/C plant and checks each
// command against a path-search reference model.
module tb_fsm1_driver;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic state_obs1, state_obs0;
  logic input1, input2;
  logic frozen = 1'b0;
  logic obs_bad = 1'b0;
  logic [1:0] pst;
  int total = 0;
  int bad = 0;
  int model_st = 0;

  fsm1_driver_if bus();

  fsm1_driver #(.TIMEOUT(TIMEOUT), .TW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .state_obs1 (state_obs1),
    .state_obs0 (state_obs0),
    .input1     (input1),
    .input2     (input2)
  );

  always #5 clk = ~clk;

  function automatic int fsm_next(input int s, input int p);
    if (s == 0 && p == 2) return 2;
    if (s == 0 && p == 1) return 1;
    if (s == 1 && p == 3) return 0;
    if (s == 2 && p == 2) return 1;
    return s;
  endfunction

  always @(posedge clk) begin
    if (reset) pst <= 2'b00;
    else if (!frozen) pst <= 2'(fsm_next(int'(pst), int'({input1, input2})));
  end

  assign {state_obs1, state_obs0} = obs_bad ? 2'b11 : pst;

  task automatic chk(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Shortest pulse path from the FSM transition rules.
  task automatic ref_plan(input int start, input int tgt, input bit fz,
                          input bit ob, output int n, output int p0,
                          output int p1, output int err, output int lat,
                          output int fin);
    n = 0; p0 = 0; p1 = 0; err = 0; lat = 2; fin = start;
    if (tgt == 3 || ob) begin
      err = 1;
    end else if (start != tgt) begin
      for (int a = 1; a <= 3; a++)
        if (n == 0 && fsm_next(start, a) == tgt) begin
          n = 1; p0 = a;
        end
      for (int a = 1; a <= 3; a++)
        for (int b = 1; b <= 3; b++)
          if (n == 0 && fsm_next(start, a) != start &&
              fsm_next(fsm_next(start, a), b) == tgt) begin
            n = 2; p0 = a; p1 = b;
          end
      if (fz) begin
        n = 1; err = 1; lat = 3 + TIMEOUT;
      end else begin
        lat = 3 * n + 1; fin = tgt;
      end
    end
  endtask

  task automatic run_cmd(input int tgt, input string tag);
    int n_e, p0, p1, err_e, lat_e, fin_e;
    int pcyc[$];
    int ppair[$];
    int rc, re, rs;
    rc = -1; re = -1; rs = -1;
    ref_plan(model_st, tgt, frozen, obs_bad, n_e, p0, p1, err_e, lat_e, fin_e);
    bus.cmd_target = 2'(tgt);
    bus.cmd_valid = 1'b1;
    chk({tag, ".ready"}, int'(bus.cmd_ready), 1);
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      if ({input1, input2} != 2'b00) begin
        pcyc.push_back(n);
        ppair.push_back(int'({input1, input2}));
      end
      if (bus.rsp_valid) begin
        rc = n; re = int'(bus.rsp_error); rs = int'(bus.rsp_steps);
        break;
      end
    end
    chk({tag, ".lat"}, rc, lat_e);
    chk({tag, ".err"}, re, err_e);
    chk({tag, ".steps"}, rs, n_e);
    chk({tag, ".npulse"}, pcyc.size(), n_e);
    for (int i = 0; i < n_e && i < pcyc.size(); i++) begin
      chk({tag, ".pcyc"}, pcyc[i], 2 + 3 * i);
      chk({tag, ".pair"}, ppair[i], (i == 0) ? p0 : p1);
    end
    model_st = fin_e;
    @(posedge clk); #1;
    chk({tag, ".idle"}, int'(bus.busy), 0);
    if (!obs_bad) chk({tag, ".fsm"}, int'(pst), model_st);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_target = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.pair", int'({input1, input2}), 0);
    chk("rst.rspv", int'(bus.rsp_valid), 0);
    chk("rst.rspe", int'(bus.rsp_error), 0);
    chk("rst.rsps", int'(bus.rsp_steps), 0);
    chk("rst.ready", int'(bus.cmd_ready), 0);
    reset = 1'b0;
    #1;
    chk("rel.ready", int'(bus.cmd_ready), 1);

    run_cmd(1, "a2b");
    run_cmd(2, "b2c");
    run_cmd(2, "c2c");
    run_cmd(3, "ill");
    obs_bad = 1'b1;
    run_cmd(0, "obs11");
    obs_bad = 1'b0;
    run_cmd(0, "c2a");

    frozen = 1'b1;
    run_cmd(1, "frz");
    frozen = 1'b0;

    run_cmd(1, "a2b2");
    bus.cmd_target = 2'b10;
    bus.cmd_valid = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      if (n == 2) chk("abort.pulse", int'({input1, input2}), 3);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort.busy", int'(bus.busy), 0);
    chk("abort.pair", int'({input1, input2}), 0);
    chk("abort.rspv", int'(bus.rsp_valid), 0);
    reset = 1'b0;
    model_st = 0;
    #1;
    chk("abort.ready", int'(bus.cmd_ready), 1);
    run_cmd(2, "post");

    for (int k = 0; k < 24; k++) begin
      obs_bad = ($urandom_range(0, 9) == 0);
      run_cmd(int'($urandom_range(0, 3)), "rnd");
    end
    obs_bad = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fsm1_driver.md
Name: fsm1_driver

Overview:
- Stimulus master for the three-state FSM (states A/B/C). It sits on the opposite side of that FSM's input1/input2 interface.
- Accepts a "go to state X" command and reads the FSM's state_obs1/state_obs0 feedback. It emits one-cycle input1/input2 pulses until the FSM reaches X.
- Reports completion, step count or error. Used by the run harness to steer the FSM into known states without hand-written input sequences.

Parameters:
- TIMEOUT, 8, maximum WAIT cycles allowed for the FSM to reflect one step (must be 2..15).
- TW, 4, width of the wait timer.

Ports:
- clk  in  1  rising-edge clock, shared with the FSM
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_target  in  2  target state: 00=A, 01=B, 10=C, 11=illegal
- cmd_ready  out  1  high iff the block is in IDLE and reset is low
- state_obs1  in  1  FSM state observation, bit 1
- state_obs0  in  1  FSM state observation, bit 0
- input1  out  1  FSM stimulus bit 1
- input2  out  1  FSM stimulus bit 2
- rsp_valid  out  1  one-cycle response strobe
- rsp_error  out  1  qualified by rsp_valid; 1 = failure
- rsp_steps  out  2  qualified by rsp_valid; number of pulses issued (0..2)
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset:
  - Single clock clk. Reset is synchronous and active-high, on port reset.
  - Reset forces state IDLE and the following outputs: input1=0, input2=0, rsp_valid=0, rsp_error=0, rsp_steps=0, busy=0, cmd_ready=0.
  - Reset mid-operation aborts with no response. Any pulse in flight is dropped and the pulse pair returns to 00 the next cycle.
- FSM model being driven (obs encoding A=00, B=01, C=10, 11=invalid):
  - A: pair (1,0) goes to C; pair (0,1) goes to B.
  - B: pair (1,1) goes to A.
  - C: pair (1,0) goes to B.
  - All other pairs hold the current state; pair (0,0) is the idle code.
- Step table (current state -> target: pair, intermediate):
  - A->B: (0,1)
  - A->C: (1,0)
  - B->A: (1,1)
  - C->B: (1,0)
  - B->C: (1,1) via A, then (1,0)
  - C->A: (1,0) via B, then (1,1)
- States:
  - IDLE: cmd_ready=1. When cmd_valid and cmd_ready are both high, latch cmd_target, clear the step count, go to PLAN.
  - PLAN (1 cycle): sample obs.
    - If the target is 11 or obs is 11: go to RESP with error.
    - If obs equals the target: go to RESP with no error.
    - Otherwise: register the pair and the expected next state from the table, record obs as prev, go to DRIVE.
  - DRIVE (1 cycle): input1/input2 equal the registered pair for exactly this cycle. Increment steps, clear the timer, go to WAIT.
  - WAIT: pair is 00; the timer increments each cycle.
    - If obs equals expected and expected equals the target: go to RESP, no error.
    - If obs equals expected but is not the target: go to PLAN.
    - If obs differs from both prev and expected: go to RESP with error.
    - If the timer equals TIMEOUT-1 with no match: go to RESP with error.
  - RESP (1 cycle): rsp_valid=1, with rsp_error and rsp_steps valid. Go to IDLE.
- Outputs:
  - input1/input2 are registered and are 00 in every state except DRIVE.
  - A new command cannot be accepted in the RESP cycle.
- Latency, counted from the accept cycle c:
  - 0 steps: rsp_valid at c+2.
  - 1 step: DRIVE at c+2, rsp_valid at c+4 (FSM responding immediately).
  - 2 steps: DRIVE at c+2 and c+5, rsp_valid at c+7.
- Error response: rsp_steps reports the pulses issued before the error was detected.

Test Plan:
- Reset, then obs=00, command target=01:
  - pulse (0,1) at c+2;
  - model FSM moves to B, obs=01 at c+3;
  - rsp_valid at c+4 with rsp_error=0, rsp_steps=1.
- FSM in B (obs=01), target=10:
  - pulse (1,1) at c+2, then (1,0) at c+5;
  - rsp_valid at c+7 with rsp_error=0, rsp_steps=2;
  - input1/input2=00 in every other cycle.
- obs=10, target=10:
  - no pulse;
  - rsp_valid at c+2 with rsp_error=0, rsp_steps=0.
- Target=11, and separately obs forced to 11:
  - rsp_valid at c+2 with rsp_error=1, rsp_steps=0;
  - no pulse issued.
- FSM model frozen (ignores inputs), obs=00, target=01, TIMEOUT=8:
  - one pulse at c+2;
  - rsp_error=1, rsp_steps=1 at c+11.
- Reset asserted in the cycle after a DRIVE of a 2-step command:
  - next cycle: busy=0, pair=00, no rsp_valid;
  - cmd_ready=1 once reset deasserts;
  - a new command completes normally.
